// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter for N requesters with a per-channel enable mask, grant locking
// until release, and a forced rotation when a holder exceeds HOLD_MAX cycles.
module rr_arbiter_param #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 15,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic             release_i,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [N-1:0]     elig;
    logic [N-1:0]     arb_elig;
    logic             end_normal;
    logic             end_hold;
    logic             forced;
    logic             found;
    logic [IDX_W-1:0] winner;

    always_comb begin
        elig       = req & mask;
        end_normal = (state_q == BUSY) &&
                     (release_i || !req[gnt_idx_q] || !mask[gnt_idx_q]);
        end_hold   = (state_q == BUSY) && (HOLD_MAX != 0) && (hold_cnt_q == CNT_LAST);
        forced     = end_hold && !end_normal;

        // A holder rotated out by the timeout sits out exactly this one arbitration.
        arb_elig = forced ? (elig & ~gnt_q) : elig;

        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && arb_elig[(int'(ptr_q) + i) % N]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(ptr_q) + i) % N);
            end
        end

        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = forced;

        if (state_q == IDLE || end_normal || end_hold) begin
            hold_cnt_d = '0;
            if (found) begin
                state_d        = BUSY;
                gnt_d          = '0;
                gnt_d[winner]  = 1'b1;
                gnt_idx_d      = winner;
                gnt_valid_d    = 1'b1;
                ptr_d          = (int'(winner) == N - 1) ? '0 : winner + 1'b1;
            end else begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        end else if (hold_cnt_q != CNT_SAT) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised round-robin arbiter with grant locking and a hold-timeout, serving N requesters from one shared resource. It succeeds the fixed 4-input counter-scanned arbiter and replaces blind counter rotation with work-conserving pointer rotation. It adds a per-channel enable mask, a grant held until released, and a forced rotation when one requester holds the grant too long. Grant outputs are registered, so the block drops directly between requester logic and the shared-resource mux.

## Interface
- N, default 4: number of requesters; legal range 2..32.
- HOLD_MAX, default 15: maximum cycles a grant may be held; 0 disables the timeout.
- IDX_W, default $clog2(N): width of the grant index; derived, never overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i is requester i.
- mask  in  N  enable vector; a requester is eligible only if req[i] & mask[i].
- release  in  1  the current holder is done with the resource.
- gnt  out  N  one-hot grant, registered; all zeros when idle.
- gnt_idx  out  IDX_W  binary index of the granted requester; 0 when idle.
- gnt_valid  out  1  a grant is active (equals |gnt).
- timeout  out  1  one-cycle pulse: the previous grant was force-ended by HOLD_MAX.

## Operation
- State: IDLE / BUSY.
- Registers:
  - ptr: IDX_W bits, highest-priority slot.
  - hold_cnt: counts cycles in BUSY.
  - registered gnt, gnt_idx, gnt_valid and timeout.
- Eligibility: elig = req & mask.
- Arbitration:
  - The winner is the first set bit of elig scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (circular, mod N).
  - The scan is combinational and evaluated every cycle.
- IDLE:
  - If elig is nonzero, load gnt/gnt_idx with the winner, set gnt_valid, set ptr to (winner+1) mod N, clear hold_cnt, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, holder h = gnt_idx:
  - The grant is held unchanged while no end condition is true.
  - hold_cnt increments each cycle and saturates.
- BUSY end conditions, evaluated at each edge:
  - (a) release = 1;
  - (b) req[h] = 0;
  - (c) mask[h] = 0;
  - (d) HOLD_MAX != 0 and hold_cnt == HOLD_MAX-1, meaning gnt_valid has been high for HOLD_MAX cycles.
- On the end edge, the block re-arbitrates in the same edge (back-to-back, no idle bubble):
  - If another requester is eligible, grant it, update ptr and clear hold_cnt; remain in BUSY.
  - If no requester is eligible, clear gnt, gnt_idx and gnt_valid, and go to IDLE.
- Re-arbitration after a normal end, conditions (a)-(c): h keeps its place in the scan. Because ptr already sits at h+1, h is lowest priority and wins only if it is the sole eligible requester.
- Re-arbitration after a timeout, condition (d) alone:
  - h is excluded from that one arbitration.
  - If h is the only eligible requester, the block goes to IDLE for one cycle; h may re-win next cycle.
- timeout is set for exactly one cycle, the cycle after an edge where (d) ended the grant and (a)-(c) were all false.
- Precedence: if (a)/(b)/(c) coincide with (d), the end counts as normal and timeout stays 0.
- Masked requests are never granted; a mask change takes effect at the next arbitration edge.
- ptr changes only when a grant is issued; it is never advanced in IDLE.

## Timing
- Reset (rst = 0, asynchronous):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0;
  - ptr = 0, hold_cnt = 0, state IDLE.
- After deassertion, the first grant can appear one edge after req is sampled.
- Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Latency:
  - req is sampled at edge k; gnt is visible after edge k, one cycle.
  - release is sampled at edge k; the next gnt is visible after edge k.
- Grants are one-hot at all times; gnt_valid == |gnt; gnt_idx is consistent with gnt in every cycle.
- With HOLD_MAX = M, a continuously requesting holder with no release sees gnt_valid high for exactly M consecutive cycles.
- Fairness: with all N requesters continuously eligible and release pulsed every cycle, each requester is granted exactly once in any N consecutive grants.

## Test plan
- Reset then req = 4'b1111, mask = 4'b1111, release held high, N = 4 → gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; gnt_idx 0, 1, 2, 3, 0.
- req = 4'b0101, release pulsed each cycle → grants alternate 0001/0100, with no cycle spent on requesters 1 or 3.
- req = 4'b0001 only, release = 0, HOLD_MAX = 15 → gnt = 0001 for 15 cycles, then gnt = 0 for one cycle with timeout = 1, then gnt = 0001 again.
- req = 4'b0011, holder 0, release = 0, HOLD_MAX = 4 → after 4 cycles gnt switches directly to 0010 and timeout pulses once; no idle cycle.
- mask = 4'b1011 with req = 4'b1111 → requester 2 is never granted; clearing mask[1] while 1 holds ends its grant at the next edge.
- rst asserted low while gnt = 0100 → gnt, gnt_valid and timeout go 0 asynchronously; after release of reset, the next grant starts scanning at requester 0.
